// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op-mode codes, scheduler state
// encoding and a width helper used to size requester ids and counters.
package alu_pkg;

  // ALU op-mode codes; code 7 is undefined and treated as single-cycle.
  localparam logic [2:0] OP_IDLE        = 3'd0;
  localparam logic [2:0] OP_LOGIC       = 3'd1;
  localparam logic [2:0] OP_SHIFT       = 3'd2;
  localparam logic [2:0] OP_COMPARE     = 3'd3;
  localparam logic [2:0] OP_INT_ADD_SUB = 3'd4;
  localparam logic [2:0] OP_INT_MUL     = 3'd5;
  localparam logic [2:0] OP_INT_DIV     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // ceil(log2(n)) but never below 1, so a single-entry range still gets a bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// after the pointer, wrapping around, and reports the winner as one-hot and
// as an index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_id,
  output logic          grant_valid
);

  // Scan N positions starting at the pointer; the first hit wins.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = CW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between N requesters. One op is in
// flight at a time: accept (IDLE), execute with MUL/DIV stall tracking and a
// busy timeout (EXEC), then hold the registered result until the requester
// takes it (RESP).
module alu_sched
  import alu_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 64,
  parameter int CW      = clog2_min1(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req_valid,
  output logic [N-1:0]    o_req_ready,
  input  logic [3*N-1:0]  i_req_op_mode,
  input  logic [3*N-1:0]  i_req_func_op,
  input  logic [N-1:0]    i_req_fp_mode,
  input  logic [32*N-1:0] i_req_a,
  input  logic [32*N-1:0] i_req_b,
  output logic [N-1:0]    o_resp_valid,
  input  logic [N-1:0]    i_resp_ready,
  output logic [31:0]     o_resp_data,
  output logic            o_resp_err,
  output logic [CW-1:0]   o_resp_id,
  output logic [2:0]      o_alu_op_mode,
  output logic [2:0]      o_alu_func_op,
  output logic            o_alu_fp_mode,
  output logic            o_alu_stall,
  input  logic            i_alu_busy,
  output logic [31:0]     o_alu_a,
  output logic [31:0]     o_alu_b,
  input  logic [31:0]     i_alu_result
);

  localparam int CNT_W = clog2_min1(TIMEOUT);

  sched_state_e state, next_state;

  logic [CW-1:0]    ptr;
  logic [N-1:0]     grant;
  logic [CW-1:0]    grant_id;
  logic             grant_valid;

  logic [2:0]       lat_op;
  logic [2:0]       lat_func;
  logic             lat_fp;
  logic [31:0]      lat_a;
  logic [31:0]      lat_b;
  logic [CW-1:0]    lat_id;
  logic             err;
  logic [CNT_W-1:0] wait_cnt;

  logic             accept;
  logic             timeout_hit;
  logic             resp_fire;

  int unsigned      gsel;
  logic [2:0]       pick_op;
  logic [2:0]       pick_func;
  logic             pick_fp;
  logic [31:0]      pick_a;
  logic [31:0]      pick_b;

  rr_arbiter #(
    .N  (N),
    .CW (CW)
  ) u_arb (
    .req         (i_req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Operand slices of the winning requester.
  assign gsel      = 32'(grant_id);
  assign pick_op   = i_req_op_mode[3*gsel +: 3];
  assign pick_func = i_req_func_op[3*gsel +: 3];
  assign pick_fp   = i_req_fp_mode[gsel];
  assign pick_a    = i_req_a[32*gsel +: 32];
  assign pick_b    = i_req_b[32*gsel +: 32];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode plus the accept/timeout/response-fire strobes.
  always_comb begin
    next_state  = state;
    o_req_ready = '0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    resp_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          o_req_ready = grant;
          accept      = 1'b1;
          next_state  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!i_alu_busy) begin
          next_state = ST_RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_resp_ready[lat_id]) begin
          resp_fire  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand latches, round-robin pointer, error flag and busy-wait counter.
  // NOTE: the operand latches are reset too, so the ALU inputs leave reset
  // at a known value rather than X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      lat_op   <= '0;
      lat_func <= '0;
      lat_fp   <= 1'b0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_id   <= '0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        lat_op   <= pick_op;
        lat_func <= pick_func;
        lat_fp   <= pick_fp;
        lat_a    <= pick_a;
        lat_b    <= pick_b;
        lat_id   <= grant_id;
        ptr      <= (grant_id == CW'(N - 1)) ? '0 : grant_id + CW'(1);
        wait_cnt <= '0;
        err      <= 1'b0;
      end
      if (state == ST_EXEC && i_alu_busy) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
      if (resp_fire) begin
        err      <= 1'b0;
        wait_cnt <= '0;
      end
    end
  end

  // Response channel: one-hot valid to the owner of the in-flight op.
  always_comb begin
    o_resp_valid = '0;
    if (state == ST_RESP) o_resp_valid[lat_id] = 1'b1;
  end

  // A timed-out op returns zero instead of whatever the ALU last registered.
  assign o_resp_data = (state == ST_RESP && !err) ? i_alu_result : 32'd0;
  assign o_resp_err  = (state == ST_RESP) && err;
  assign o_resp_id   = lat_id;

  // ALU control: op mode is only live in EXEC, so leaving EXEC (including on
  // timeout) also releases the ALU's internal MUL/DIV sequencing.
  assign o_alu_op_mode = (state == ST_EXEC) ? lat_op : OP_IDLE;
  assign o_alu_func_op = lat_func;
  assign o_alu_fp_mode = lat_fp;
  assign o_alu_a       = lat_a;
  assign o_alu_b       = lat_b;
  assign o_alu_stall   = (state == ST_RESP);

endmodule
